regfile_write_queue: RTL

Buffered writeback initiator for the 32×32 register file: accepts register-write requests from the execute/memory stages, queues them in a small in-order FIFO, and drives the register file's write port (`regwr`, `wreg`, `wdata`) at one write per cycle. It also snoops the register file's two read addresses and forwards the youngest still-pending value, so readers never see stale data while writes are queued. It sits between the pipeline's result sources and the `registers` write port.

---
 rtl/regfile_write_queue_pkg.sv | 15 +
 rtl/regfile_write_queue_fwd_match.sv | 31 +++
 rtl/regfile_write_queue.sv | 108 ++++++++++
 3 files changed

// File: rtl/regfile_write_queue_pkg.sv
// Shared defaults and types for the register-file writeback queue.
package regfile_write_queue_pkg;

    localparam int unsigned AW_DEF    = 5;
    localparam int unsigned DW_DEF    = 32;
    localparam int unsigned DEPTH_DEF = 4;

    localparam logic [AW_DEF-1:0] ZERO_REG = 5'd0;

    typedef struct packed {
        logic [AW_DEF-1:0] rg;
        logic [DW_DEF-1:0] data;
    } wbq_entry_t;

endpackage

// File: rtl/regfile_write_queue_fwd_match.sv
// Youngest-first match of one read address over the age-ordered pending entries.
module wbq_fwd_match
    import regfile_write_queue_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned AW    = AW_DEF,
    parameter int unsigned DW    = DW_DEF
) (
    input  logic [AW-1:0]                rreg,
    input  logic [DEPTH-1:0]             valid,
    input  logic [DEPTH-1:0][AW-1:0]     regs,
    input  logic [DEPTH-1:0][DW-1:0]     datas,
    output logic                         hit,
    output logic [DW-1:0]                data
);

    // Index 0 is the oldest entry; later matches overwrite earlier ones.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        if (rreg != AW'(ZERO_REG)) begin
            for (int k = 0; k < int'(DEPTH); k++) begin
                if (valid[k] && (regs[k] == rreg)) begin
                    hit  = 1'b1;
                    data = datas[k];
                end
            end
        end
    end

endmodule

// File: rtl/regfile_write_queue.sv
// In-order writeback FIFO driving the register-file write port, with read-port forwarding.
module regfile_write_queue
    import regfile_write_queue_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned AW    = AW_DEF,
    parameter int unsigned DW    = DW_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [AW-1:0]                in_reg,
    input  logic [DW-1:0]                in_data,
    output logic                         regwr,
    output logic [AW-1:0]                wreg,
    output logic [DW-1:0]                wdata,
    input  logic [AW-1:0]                rreg1,
    input  logic [AW-1:0]                rreg2,
    output logic                         fwd1_hit,
    output logic                         fwd2_hit,
    output logic [DW-1:0]                fwd1_data,
    output logic [DW-1:0]                fwd2_data,
    output logic [$clog2(DEPTH):0]       count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [AW-1:0] mem_reg  [DEPTH];
    logic [DW-1:0] mem_data [DEPTH];
    logic [PW-1:0] head, tail;
    logic [CW-1:0] cnt;

    logic push, pop;

    logic [DEPTH-1:0]         ord_valid;
    logic [DEPTH-1:0][AW-1:0] ord_reg;
    logic [DEPTH-1:0][DW-1:0] ord_data;

    // Register-0 requests complete the handshake but never occupy an entry.
    assign in_ready = rst && (cnt < CW'(DEPTH));
    assign push     = in_valid && in_ready && (in_reg != AW'(ZERO_REG));
    assign pop      = (cnt != '0);
    assign count    = cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (push) tail <= tail + PW'(1);
            if (pop)  head <= head + PW'(1);
            unique case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Payload storage needs no reset; occupancy gates every use of it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_reg[tail]  <= in_reg;
            mem_data[tail] <= in_data;
        end
    end

    always_comb begin
        regwr = pop;
        wreg  = '0;
        wdata = '0;
        if (pop) begin
            wreg  = mem_reg[head];
            wdata = mem_data[head];
        end
    end

    // Rotate storage into age order so the matcher sees oldest at index 0.
    always_comb begin
        for (int k = 0; k < int'(DEPTH); k++) begin
            ord_valid[k] = (CW'(k) < cnt);
            ord_reg[k]   = mem_reg[head + PW'(k)];
            ord_data[k]  = mem_data[head + PW'(k)];
        end
    end

    wbq_fwd_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fwd1 (
        .rreg  (rreg1),
        .valid (ord_valid),
        .regs  (ord_reg),
        .datas (ord_data),
        .hit   (fwd1_hit),
        .data  (fwd1_data)
    );

    wbq_fwd_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fwd2 (
        .rreg  (rreg2),
        .valid (ord_valid),
        .regs  (ord_reg),
        .datas (ord_data),
        .hit   (fwd2_hit),
        .data  (fwd2_data)
    );

endmodule
